// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch controller, the ALU and the decoder:
// opcode values, controller state encoding and default widths.
package fetch_ctrl_pkg;

    localparam int PC_W_DEF = 8;
    localparam int CT_W_DEF = 16;

    typedef enum logic [2:0] {
        OP_STP  = 3'b000,
        OP_SHF  = 3'b001,
        OP_BNEG = 3'b010,
        OP_NOR  = 3'b011,
        OP_ADD  = 3'b100,
        OP_ADDI = 3'b101,
        OP_ST   = 3'b110,
        OP_LD   = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_e;

endpackage

// File: rtl/branch_lut.sv
// Constant 64-entry branch-target table with a combinational read.
// Entry i holds the address i*4 + 12, truncated to PC_W bits.
module branch_lut
    import fetch_ctrl_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic [5:0]      Index,
    output logic [PC_W-1:0] Target
);

    always_comb begin
        Target = PC_W'(({2'b00, Index} << 2) + 8'd12);
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: sequences the PC through the instruction ROM,
// handles stp/bneg, stalls, and counts committed instructions.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int PC_W = PC_W_DEF,
    parameter int CT_W = CT_W_DEF
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            Start,
    input  logic [8:0]      Instr,
    input  logic            AluZero,
    input  logic            Stall,
    output logic [PC_W-1:0] PC,
    output logic [2:0]      OP,
    output logic [5:0]      Operand,
    output logic            Exec,
    output logic            Halt,
    output logic [CT_W-1:0] CycleCt
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [CT_W-1:0] ct_q, ct_d;
    logic [PC_W-1:0] branchTarget;
    logic            execRun;
    opcode_e         opcode;

    assign opcode  = opcode_e'(Instr[8:6]);
    assign OP      = Instr[8:6];
    assign Operand = Instr[5:0];

    branch_lut #(.PC_W(PC_W)) u_branch_lut (
        .Index  (Instr[5:0]),
        .Target (branchTarget)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ct_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ct_q    <= ct_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ct_d    = ct_q;
        execRun = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pc_d = '0;
                if (Start) begin
                    state_d = ST_RUN;
                    ct_d    = '0;
                end
            end
            ST_RUN: begin
                if (!Stall) begin
                    execRun = 1'b1;
                    // The counter sticks at all-ones rather than wrapping.
                    if (ct_q != '1) begin
                        ct_d = ct_q + CT_W'(1);
                    end
                    case (opcode)
                        OP_STP:  state_d = ST_HALT;
                        OP_BNEG: pc_d = AluZero ? branchTarget : pc_q + PC_W'(1);
                        default: pc_d = pc_q + PC_W'(1);
                    endcase
                end
            end
            ST_HALT: begin
                if (Start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                    ct_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = '0;
                ct_d    = '0;
            end
        endcase
    end

    // Reset aborts an in-flight instruction, so it must also suppress the commit strobe.
    assign Exec    = execRun & ~Reset;
    assign Halt    = (state_q == ST_HALT);
    assign PC      = pc_q;
    assign CycleCt = ct_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl; a second instance with a 4-bit counter
// exercises counter saturation alongside the main instance.
module tb_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        AluZero = 1'b0;
    logic        Stall = 1'b0;
    logic [8:0]  Instr, instrSmall;
    logic [7:0]  PC, pcSmall;
    logic [2:0]  OP, opSmall;
    logic [5:0]  Operand, operandSmall;
    logic        Exec, execSmall;
    logic        Halt, haltSmall;
    logic [15:0] CycleCt;
    logic [3:0]  ctSmall;

    logic [8:0]  rom [256];

    typedef struct {
        string tag;
        int    pc;
        bit    halt;
        int    ct;
        int    ctSmall;
    } exp_t;

    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [8:0] I_ADD  = 9'b100_000000;
    localparam logic [8:0] I_STP  = 9'b000_000000;
    localparam logic [8:0] I_SHF  = 9'b001_000000;
    localparam logic [8:0] I_LD   = 9'b111_000000;
    localparam logic [8:0] I_BNEG = 9'b010_000101;

    always #5 CLK = ~CLK;

    assign Instr      = rom[PC];
    assign instrSmall = rom[pcSmall];

    fetch_ctrl dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .Start   (Start),
        .Instr   (Instr),
        .AluZero (AluZero),
        .Stall   (Stall),
        .PC      (PC),
        .OP      (OP),
        .Operand (Operand),
        .Exec    (Exec),
        .Halt    (Halt),
        .CycleCt (CycleCt)
    );

    fetch_ctrl #(.PC_W(8), .CT_W(4)) dutSmall (
        .CLK     (CLK),
        .Reset   (Reset),
        .Start   (Start),
        .Instr   (instrSmall),
        .AluZero (AluZero),
        .Stall   (Stall),
        .PC      (pcSmall),
        .OP      (opSmall),
        .Operand (operandSmall),
        .Exec    (execSmall),
        .Halt    (haltSmall),
        .CycleCt (ctSmall)
    );

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One clock of stimulus: drive inputs, check the commit strobe before the
    // edge, then pop the expected post-edge state and compare.
    task automatic applyStimulus(input string tag, input bit rst, input bit st,
                                 input bit stl, input bit az, input int ePc,
                                 input bit eHalt, input int eCt, input bit eExec);
        exp_t e;
        Reset   = rst;
        Start   = st;
        Stall   = stl;
        AluZero = az;
        sb.push_back('{tag, ePc, eHalt, eCt, (eCt > 15) ? 15 : eCt});
        #2;
        checkOutput({tag, ".exec"}, 32'(Exec), 32'(eExec));
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        checkOutput({e.tag, ".pc"}, 32'(PC), e.pc);
        checkOutput({e.tag, ".halt"}, 32'(Halt), 32'(e.halt));
        checkOutput({e.tag, ".ct"}, 32'(CycleCt), e.ct);
        checkOutput({e.tag, ".ctSat"}, 32'(ctSmall), e.ctSmall);
    endtask

    task automatic fillRom(input logic [8:0] word);
        for (int i = 0; i < 256; i++) rom[i] = word;
    endtask

    initial begin
        fillRom(I_ADD);

        // Reset state
        applyStimulus("reset", 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("idleHold", 0, 0, 0, 0, 0, 0, 0, 0);

        // Ten adds then stp at PC 10, with Start toggled mid-run to show it is ignored
        rom[10] = I_STP;
        applyStimulus("start", 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            applyStimulus("addRun", 0, (i == 4), 0, 0, i + 1, 0, i + 1, 1);
        applyStimulus("stp", 0, 0, 0, 0, 10, 1, 11, 1);
        applyStimulus("haltHold", 0, 0, 0, 1, 10, 1, 11, 0);
        applyStimulus("restart", 0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus("afterRestart", 0, 0, 0, 0, 1, 0, 1, 1);

        // bneg taken and not taken; AluZero ignored on add
        fillRom(I_ADD);
        rom[3] = I_BNEG;
        applyStimulus("reset2", 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("start2", 0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus("addAzIgnored", 0, 0, 0, 1, 1, 0, 1, 1);
        applyStimulus("add2", 0, 0, 0, 0, 2, 0, 2, 1);
        applyStimulus("add3", 0, 0, 0, 0, 3, 0, 3, 1);
        checkOutput("opPass", 32'(OP), 32'(3'b010));
        checkOutput("operandPass", 32'(Operand), 32'd5);
        applyStimulus("bnegTaken", 0, 0, 0, 1, 32'h20, 0, 4, 1);
        applyStimulus("afterBranch", 0, 0, 0, 0, 32'h21, 0, 5, 1);
        applyStimulus("reset3", 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("start3", 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            applyStimulus("toBneg", 0, 0, 0, 0, i + 1, 0, i + 1, 1);
        applyStimulus("bnegNotTaken", 0, 0, 0, 0, 4, 0, 4, 1);

        // Three-cycle stall on ld at PC 7
        fillRom(I_ADD);
        rom[7] = I_LD;
        applyStimulus("reset4", 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("start4", 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++)
            applyStimulus("toLd", 0, 0, 0, 0, i + 1, 0, i + 1, 1);
        for (int i = 0; i < 3; i++)
            applyStimulus("stall", 0, 0, 1, 0, 7, 0, 7, 0);
        applyStimulus("ldCommit", 0, 0, 0, 0, 8, 0, 8, 1);

        // All shf: PC wraps 0xFF -> 0x00 without halting; small counter saturates
        fillRom(I_SHF);
        applyStimulus("reset5", 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("start5", 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 260; i++)
            applyStimulus("wrap", 0, 0, 0, 0, (i + 1) % 256, 0, i + 1, 1);

        // Reset mid-stall in RUN at PC 0x12 with Start high wins and lands in IDLE
        applyStimulus("reset6", 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("start6", 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32'h12; i++)
            applyStimulus("toPc12", 0, 0, 0, 0, i + 1, 0, i + 1, 1);
        applyStimulus("stallPc12", 0, 0, 1, 0, 32'h12, 0, 32'h12, 0);
        applyStimulus("resetMidStall", 1, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus("idleAfterReset", 0, 0, 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
